// File: rtl/shot_charge_controller.sv
// Cue shot sequencer: charge power while the shot key is held, fire a one-cycle
// strike pulse on release, then cool down and wait for the table to settle.
module shot_charge_controller #(
  parameter int POWER_W         = 6,
  parameter int POWER_MAX       = 63,
  parameter int MIN_POWER       = 4,
  parameter int STEP_FRAMES     = 2,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               keyRisingEdgePulse,
  input  logic               keyIsPressed,
  input  logic               abortKey,
  input  logic               ballsMoving,
  output logic [POWER_W-1:0] shotPower,
  output logic               shotFire,
  output logic               charging,
  output logic               ready
);

  localparam int FRAME_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int COOL_W  = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(STEP_FRAMES - 1);
  localparam logic [COOL_W-1:0]  COOL_LAST  = COOL_W'(COOLDOWN_FRAMES - 1);
  localparam logic [POWER_W-1:0] POWER_TOP  = POWER_W'(POWER_MAX);
  localparam logic [POWER_W-1:0] POWER_MIN  = POWER_W'(MIN_POWER);

  typedef enum logic [2:0] {
    IDLE,
    CHARGE,
    FIRE,
    COOLDOWN,
    SETTLE
  } state_t;

  state_t             state, state_next;
  logic [POWER_W-1:0] power_next;
  logic [FRAME_W-1:0] frame_cnt, frame_next;
  logic [COOL_W-1:0]  cool_cnt, cool_next;

  // NOTE: every variable gets its hold value before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    power_next = shotPower;
    frame_next = frame_cnt;
    cool_next  = cool_cnt;
    unique case (state)
      IDLE: begin
        // Only a fresh edge arms a charge; a key still held from before is ignored.
        if (keyRisingEdgePulse && !ballsMoving) begin
          state_next = CHARGE;
          power_next = POWER_MIN;
          frame_next = '0;
        end
      end
      CHARGE: begin
        if (abortKey) begin
          state_next = IDLE;
          power_next = '0;
        end else if (!keyIsPressed) begin
          // A frame step landing on the release cycle is dropped on purpose.
          state_next = FIRE;
        end else if (startOfFrame) begin
          if (frame_cnt == FRAME_LAST) begin
            frame_next = '0;
            if (shotPower < POWER_TOP) power_next = shotPower + POWER_W'(1);
          end else begin
            frame_next = frame_cnt + FRAME_W'(1);
          end
        end
      end
      FIRE: begin
        state_next = COOLDOWN;
        cool_next  = '0;
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          cool_next = cool_cnt + COOL_W'(1);
          if (cool_cnt == COOL_LAST) state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (!ballsMoving) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      shotPower <= '0;
      frame_cnt <= '0;
      cool_cnt  <= '0;
      shotFire  <= 1'b0;
    end else begin
      state     <= state_next;
      shotPower <= power_next;
      frame_cnt <= frame_next;
      cool_cnt  <= cool_next;
      shotFire  <= (state == FIRE);
    end
  end

  assign charging = (state == CHARGE);
  assign ready    = (state == IDLE) && !ballsMoving;

endmodule

// File: tb/tb_shot_charge_controller.sv
// Self-checking bench for shot_charge_controller: fired shots are predicted into
// a scoreboard queue at release time and matched against each shotFire pulse.
module tb_shot_charge_controller;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       keyRisingEdgePulse;
  logic       keyIsPressed;
  logic       abortKey;
  logic       ballsMoving;
  logic [5:0] shotPower;
  logic       shotFire;
  logic       charging;
  logic       ready;

  typedef struct {
    int unsigned power;
    int unsigned cyc;
  } shot_t;

  shot_t       sb[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  shot_charge_controller dut (
    .clk                (clk),
    .resetN             (resetN),
    .startOfFrame       (startOfFrame),
    .keyRisingEdgePulse (keyRisingEdgePulse),
    .keyIsPressed       (keyIsPressed),
    .abortKey           (abortKey),
    .ballsMoving        (ballsMoving),
    .shotPower          (shotPower),
    .shotFire           (shotFire),
    .charging           (charging),
    .ready              (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Strike monitor: every pulse must match the oldest predicted shot.
  always @(negedge clk) begin
    if (shotFire) begin
      if (sb.size() == 0) begin
        check("unexpected_fire", 1, 0);
      end else begin
        shot_t e;
        e = sb.pop_front();
        check("fire_power", shotPower, e.power);
        check("fire_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick(1);
      startOfFrame = 1'b0;
      tick(2);
    end
  endtask

  task automatic press();
    keyRisingEdgePulse = 1'b1;
    keyIsPressed       = 1'b1;
    tick(1);
    keyRisingEdgePulse = 1'b0;
  endtask

  task automatic release_key(input int unsigned power);
    shot_t e;
    e.power = power;
    e.cyc   = cyc + 2;
    sb.push_back(e);
    keyIsPressed = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    resetN             = 1'b0;
    startOfFrame       = 1'b0;
    keyRisingEdgePulse = 1'b0;
    keyIsPressed       = 1'b0;
    abortKey           = 1'b0;
    ballsMoving        = 1'b0;
    tick(3);
    check("rst_power", shotPower, 0);
    check("rst_fire", shotFire, 0);
    check("rst_charging", charging, 0);
    check("rst_ready", ready, 1);
    resetN = 1'b1;
    tick(1);
    ballsMoving = 1'b1;
    #1 check("idle_ready_moving", ready, 0);
    ballsMoving = 1'b0;
    #1 check("idle_ready", ready, 1);

    // Basic shot: 10 frames at 2 frames/step gives 4 + 5 = 9.
    press();
    check("chg_charging", charging, 1);
    check("chg_start_power", shotPower, 4);
    check("chg_ready", ready, 0);
    frames(10);
    check("chg_power_10f", shotPower, 9);
    release_key(9);
    check("fire_not_charging", charging, 0);
    tick(1);
    frames(29);
    check("cool_29_ready", ready, 0);
    frames(1);
    tick(1);
    check("cool_done_ready", ready, 1);

    // Saturation: 62 after 116 frames, capped at 63 through 200 frames.
    press();
    frames(116);
    check("sat_power_116f", shotPower, 62);
    frames(84);
    check("sat_power_200f", shotPower, 63);
    release_key(63);
    tick(1);
    frames(30);
    tick(1);
    check("sat_back_ready", ready, 1);

    // Abort together with release: no fire, power cleared.
    press();
    frames(4);
    check("abort_pre_power", shotPower, 6);
    abortKey     = 1'b1;
    keyIsPressed = 1'b0;
    tick(1);
    abortKey = 1'b0;
    check("abort_power", shotPower, 0);
    check("abort_charging", charging, 0);
    check("abort_ready", ready, 1);
    tick(4);

    // Key activity during COOLDOWN and SETTLE with balls moving is ignored.
    press();
    frames(2);
    check("busy_pre_power", shotPower, 5);
    ballsMoving = 1'b1;
    release_key(5);
    tick(1);
    for (int i = 0; i < 30; i++) begin
      frames(1);
      keyRisingEdgePulse = 1'b1;
      keyIsPressed       = 1'b1;
      abortKey           = (i == 3);
      tick(1);
      keyRisingEdgePulse = 1'b0;
      abortKey           = 1'b0;
      if (i == 10) check("cool_key_ignored", charging, 0);
    end
    frames(5);
    press();
    check("settle_key_ignored", charging, 0);
    check("settle_ready", ready, 0);
    check("settle_power_held", shotPower, 5);
    ballsMoving = 1'b0;
    tick(2);
    check("settle_to_idle_ready", ready, 1);
    check("held_key_no_charge", charging, 0);
    keyIsPressed = 1'b0;
    ballsMoving  = 1'b1;
    press();
    check("idle_moving_ignored", charging, 0);
    keyIsPressed = 1'b0;
    ballsMoving  = 1'b0;
    tick(1);

    // Async reset mid-charge at power 7.
    press();
    frames(6);
    check("mid_power", shotPower, 7);
    #2 resetN = 1'b0;
    #1;
    check("async_power", shotPower, 0);
    check("async_charging", charging, 0);
    check("async_fire", shotFire, 0);
    keyIsPressed = 1'b0;
    tick(3);
    resetN = 1'b1;
    tick(1);
    press();
    check("post_rst_power", shotPower, 4);
    release_key(4);
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick(1);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
